dcache_miss_controller: RTL and testbench
=========================================

# dcache_miss_controller

Sequencing controller for the data cache sitting between the single-cycle datapath and main memory. It detects load misses and stores, freezes the datapath with `Stall`, runs a multi-word block refill or a write-through transaction over a ready-handshake memory port, and releases the instruction for exactly one retire cycle. It drives the cache's fill/update enables and the refill word offset; address formation stays in the cache.

## Interface
- `WORDS_PER_BLOCK`, 4, words per cache block; power of two, ≥2
- `OFF_W`, `$clog2(WORDS_PER_BLOCK)`, width of `Refill_Offset`

- `CLK`  in  1  rising-edge clock
- `RST`  in  1  asynchronous, active-low reset
- `MemRead`  in  1  current instruction is a load (from control unit)
- `MemWrite`  in  1  current instruction is a store (from control unit)
- `Cache_Hit`  in  1  combinational tag match for current data address
- `Mem_Ready`  in  1  main memory accepts/returns one word this cycle
- `Stall`  out  1  freeze PC, register file and all state writes
- `Mem_Req`  out  1  memory transaction active
- `Mem_We`  out  1  transaction is a write (valid with `Mem_Req`)
- `Refill_Offset`  out  OFF_W  word index within block being refilled
- `Cache_Fill_En`  out  1  write returned memory word into cache at `Refill_Offset`
- `Cache_Update_En`  out  1  write store data into cache word (write hit)
- `Stall_Count`  out  32  only with `DCACHE_STALL_CNT_EN`; see Configuration

## Operation
- States: IDLE, REFILL, WRITE, RELEASE. Encoding free.
- IDLE: `Stall` = `MemWrite | (MemRead & ~Cache_Hit)` (combinational). Next: `MemWrite` → WRITE (latch `Cache_Hit` into hit flag); else `MemRead & ~Cache_Hit` → REFILL, offset cleared to 0; else stay.
- `MemRead & MemWrite` both high: store takes priority.
- REFILL: `Stall`=1, `Mem_Req`=1, `Mem_We`=0. Each cycle with `Mem_Ready`=1: `Cache_Fill_En`=1, offset increments (mod WORDS_PER_BLOCK). On the ready cycle with offset = WORDS_PER_BLOCK-1 → RELEASE. `Mem_Ready`=0: hold, no fill.
- WRITE (write-through, no-write-allocate): `Stall`=1, `Mem_Req`=1, `Mem_We`=1 held until `Mem_Ready`=1; that cycle `Cache_Update_En` = latched hit flag; → RELEASE.
- RELEASE: `Stall`=0, `Mem_Req`=0; instruction retires (load now hits). Inputs ignored; always → IDLE.
- `Cache_Fill_En`, `Cache_Update_En` only ever high in REFILL/WRITE on `Mem_Ready` cycles; never both.
- `Mem_Ready` ignored in IDLE and RELEASE.
- Reset (any time, incl. mid-refill): state IDLE, offset 0, hit flag 0; `Mem_Req`, `Mem_We`, fills, `Refill_Offset` = 0; `Stall` follows IDLE equation. Aborted refill is not resumed.

## Timing
- `Stall` asserted combinationally in the detecting cycle; no PC advance that edge.
- `Mem_Req`/`Mem_We`/`Refill_Offset` are registered state outputs; `Cache_Fill_En`/`Cache_Update_En` are state AND `Mem_Ready`.
- Read miss, `Mem_Ready` always 1, WORDS=4: cycle 0 IDLE (stall), cycles 1–4 REFILL offsets 0,1,2,3, cycle 5 RELEASE retire. 5 stall cycles = 1 + WORDS_PER_BLOCK.
- Store, `Mem_Ready` always 1: cycle 0 IDLE, cycle 1 WRITE, cycle 2 RELEASE. 2 stall cycles; each `Mem_Ready` low cycle adds one.
- Load hit: zero stall, stays IDLE.
- Back-to-back misses: minimum one non-stalled cycle (RELEASE) between transactions.

## Configuration
- `DCACHE_STALL_CNT_EN` defined: `Stall_Count` port exists; 32-bit counter, reset 0, +1 every cycle `Stall`=1, saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then `MemRead`=1, `Cache_Hit`=1 → `Stall`=0 every cycle, `Mem_Req` never high.
- Read miss, WORDS=4, `Mem_Ready`=1 → `Cache_Fill_En` high 4 cycles with offsets 0,1,2,3; `Stall` high 5 cycles then low 1 cycle; `Stall_Count`=5 (macro on).
- Read miss with `Mem_Ready` pattern 1,0,0,1,1,0,1 → fills only on ready cycles, offsets 0–3, RELEASE one cycle after 4th fill.
- Store hit, `Mem_Ready` low 3 cycles then high → `Mem_Req`=`Mem_We`=1 for 4 cycles, `Cache_Update_En` pulses once on ready; store miss → `Cache_Update_En` never high.
- `MemRead`=`MemWrite`=1 with `Cache_Hit`=0 → WRITE path taken, no refill.
- `RST` low at refill offset 2 → all outputs 0 asynchronously, offset 0; after release with `MemRead`=1 miss, refill restarts at offset 0.

Source files
------------

// File: rtl/dcache_miss_controller.sv
// rtl/dcache_miss_controller.sv - data cache miss/store sequencer between datapath and memory
// Optional stall counter (Stall_Count port) is built when DCACHE_STALL_CNT_EN is defined.
module dcache_miss_controller #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int OFF_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             Cache_Hit,
  input  logic             Mem_Ready,
  output logic             Stall,
  output logic             Mem_Req,
  output logic             Mem_We,
  output logic [OFF_W-1:0] Refill_Offset,
  output logic             Cache_Fill_En,
  output logic             Cache_Update_En
`ifdef DCACHE_STALL_CNT_EN
  ,
  output logic [31:0]      Stall_Count
`endif
);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RELEASE} state_t;

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS_PER_BLOCK - 1);

  state_t           state_q, state_d;
  logic [OFF_W-1:0] offset_q, offset_d;
  logic             hit_q, hit_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;

  always_comb begin
    state_d         = state_q;
    offset_d        = offset_q;
    hit_d           = hit_q;
    mem_req_d       = 1'b0;
    mem_we_d        = 1'b0;
    Stall           = 1'b0;
    Cache_Fill_En   = 1'b0;
    Cache_Update_En = 1'b0;
    case (state_q)
      IDLE: begin
        Stall = MemWrite | (MemRead & ~Cache_Hit);
        // Stores win over loads when both are flagged.
        if (MemWrite) begin
          state_d   = WRITE;
          hit_d     = Cache_Hit;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
        end else if (MemRead && !Cache_Hit) begin
          state_d   = REFILL;
          offset_d  = '0;
          mem_req_d = 1'b1;
        end
      end
      REFILL: begin
        Stall     = 1'b1;
        mem_req_d = 1'b1;
        if (Mem_Ready) begin
          Cache_Fill_En = 1'b1;
          offset_d      = offset_q + OFF_W'(1);
          if (offset_q == LAST_OFF) begin
            state_d   = RELEASE;
            mem_req_d = 1'b0;
          end
        end
      end
      WRITE: begin
        Stall = 1'b1;
        if (Mem_Ready) begin
          Cache_Update_En = hit_q;
          state_d         = RELEASE;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      offset_q  <= '0;
      hit_q     <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      hit_q     <= hit_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
    end
  end

  assign Mem_Req       = mem_req_q;
  assign Mem_We        = mem_we_q;
  assign Refill_Offset = offset_q;

`ifdef DCACHE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) stall_cnt_q <= 32'd0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign Stall_Count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_miss_controller.sv
// tb/tb_dcache_miss_controller.sv - scoreboard bench for dcache_miss_controller
// Steps are {MemRead, MemWrite, Cache_Hit, Mem_Ready, expected {Stall,Req,We,Fill,Upd,Off[1:0]}}.
module tb_dcache_miss_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       MemRead = 1'b0, MemWrite = 1'b0, Cache_Hit = 1'b0, Mem_Ready = 1'b0;
  logic       Stall, Mem_Req, Mem_We, Cache_Fill_En, Cache_Update_En;
  logic [1:0] Refill_Offset;
`ifdef DCACHE_STALL_CNT_EN
  logic [31:0] Stall_Count;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [6:0] sb[$];
  logic [6:0] got, want;
  wire  [6:0] outs = {Stall, Mem_Req, Mem_We, Cache_Fill_En, Cache_Update_En, Refill_Offset};

  dcache_miss_controller #(.WORDS_PER_BLOCK(4)) dut (
    .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
    .Cache_Hit(Cache_Hit), .Mem_Ready(Mem_Ready), .Stall(Stall), .Mem_Req(Mem_Req),
    .Mem_We(Mem_We), .Refill_Offset(Refill_Offset), .Cache_Fill_En(Cache_Fill_En),
    .Cache_Update_En(Cache_Update_En)
`ifdef DCACHE_STALL_CNT_EN
    , .Stall_Count(Stall_Count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic apply_reset();
    {MemRead, MemWrite, Cache_Hit, Mem_Ready} = 4'b0000;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  task automatic drive(input logic [10:0] s);
    {MemRead, MemWrite, Cache_Hit, Mem_Ready} = s[10:7];
    sb.push_back(s[6:0]);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    {MemRead, MemWrite, Cache_Hit, Mem_Ready} = 4'b0001;
    #3;
    n_chk++;
    if (outs !== 7'b0000000) begin n_fail++; $display("FAIL reset_idle: got %b want %b", outs, 7'b0000000); end
    MemRead = 1'b1;
    #1;
    n_chk++;
    if (outs !== 7'b1000000) begin n_fail++; $display("FAIL reset_stall_eq: got %b want %b", outs, 7'b1000000); end
`ifdef DCACHE_STALL_CNT_EN
    n_chk++;
    if (Stall_Count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", Stall_Count); end
`endif
    apply_reset();
  endtask

  task automatic test_load_hit();
    logic [10:0] st[$];
    apply_reset();
    st = '{{4'b1010, 7'b0000000}, {4'b1011, 7'b0000000}, {4'b1010, 7'b0000000}, {4'b1011, 7'b0000000}};
    foreach (st[i]) begin
      drive(st[i]);
      want = sb.pop_front(); got = outs; n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL load_hit step %0d: got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_read_miss();
    logic [10:0] st[$];
    apply_reset();
    st = '{{4'b1001, 7'b1000000}, {4'b1001, 7'b1101000}, {4'b1001, 7'b1101001},
           {4'b1001, 7'b1101010}, {4'b1001, 7'b1101011}, {4'b1011, 7'b0000000},
           {4'b0000, 7'b0000000}};
    foreach (st[i]) begin
      drive(st[i]);
      want = sb.pop_front(); got = outs; n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL read_miss step %0d: got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
`ifdef DCACHE_STALL_CNT_EN
    n_chk++;
    if (Stall_Count !== 32'd5) begin n_fail++; $display("FAIL read_miss_count: got %0d want 5", Stall_Count); end
`endif
  endtask

  task automatic test_ready_pattern();
    logic [10:0] st[$];
    apply_reset();
    st = '{{4'b1000, 7'b1000000}, {4'b1001, 7'b1101000}, {4'b1000, 7'b1100001},
           {4'b1000, 7'b1100001}, {4'b1001, 7'b1101001}, {4'b1001, 7'b1101010},
           {4'b1000, 7'b1100011}, {4'b1001, 7'b1101011}, {4'b1010, 7'b0000000},
           {4'b0001, 7'b0000000}};
    foreach (st[i]) begin
      drive(st[i]);
      want = sb.pop_front(); got = outs; n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL ready_pattern step %0d: got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_store();
    logic [10:0] st[$];
    apply_reset();
    // store hit with three wait cycles, store miss, then load+store both flagged on a miss
    st = '{{4'b0110, 7'b1000000}, {4'b0110, 7'b1110000}, {4'b0110, 7'b1110000},
           {4'b0110, 7'b1110000}, {4'b0111, 7'b1110100}, {4'b0111, 7'b0000000},
           {4'b0100, 7'b1000000}, {4'b0101, 7'b1110000}, {4'b0101, 7'b0000000},
           {4'b1101, 7'b1000000}, {4'b1101, 7'b1110000}, {4'b1101, 7'b0000000},
           {4'b0001, 7'b0000000}};
    foreach (st[i]) begin
      drive(st[i]);
      want = sb.pop_front(); got = outs; n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL store step %0d: got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] st[$];
    apply_reset();
    st = '{{4'b1001, 7'b1000000}, {4'b1001, 7'b1101000}, {4'b1001, 7'b1101001},
           {4'b1001, 7'b1101010}, {4'b1001, 7'b1101011}, {4'b1001, 7'b0000000},
           {4'b1001, 7'b1000000}, {4'b1001, 7'b1101000}, {4'b1001, 7'b1101001}};
    foreach (st[i]) begin
      drive(st[i]);
      want = sb.pop_front(); got = outs; n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL back_to_back step %0d: got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [10:0] st[$];
    apply_reset();
    st = '{{4'b1001, 7'b1000000}, {4'b1001, 7'b1101000}, {4'b1001, 7'b1101001}, {4'b1000, 7'b1100010}};
    foreach (st[i]) begin
      drive(st[i]);
      want = sb.pop_front(); got = outs; n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL mid_refill step %0d: got %b want %b", i, got, want); end
      if (i != st.size() - 1) begin @(posedge CLK); #1; end
    end
    // asynchronous reset between edges, at refill offset 2
    #1 RST = 1'b0; MemRead = 1'b0;
    #1;
    n_chk++;
    if (outs !== 7'b0000000) begin n_fail++; $display("FAIL async_reset: got %b want %b", outs, 7'b0000000); end
    @(posedge CLK); #1 RST = 1'b1;
    st = '{{4'b1001, 7'b1000000}, {4'b1001, 7'b1101000}, {4'b1001, 7'b1101001}};
    foreach (st[i]) begin
      drive(st[i]);
      want = sb.pop_front(); got = outs; n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL refill_restart step %0d: got %b want %b", i, got, want); end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_read_miss();
    test_ready_pattern();
    test_store();
    test_back_to_back();
    test_reset_mid_refill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
